// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers.
// A grant is held for a whole packet or MAX_BURST beats, whichever ends first.
module fifo_wr_arbiter #(
    parameter int BITS      = 32,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 8
) (
    input  logic                           wr_clk,
    input  logic                           wr_rst_n,
    input  logic [NREQ-1:0]                req_valid,
    input  logic [NREQ-1:0]                req_last,
    input  logic [NREQ*BITS-1:0]           req_data,
    output logic [NREQ-1:0]                req_ready,
    output logic                           fifo_wr_en,
    output logic [BITS-1:0]                fifo_wr_data,
    input  logic                           fifo_wr_full,
    output logic                           grant_valid,
    output logic [$clog2(NREQ)-1:0]        grant_id,
    output logic [$clog2(MAX_BURST+1)-1:0] beat_cnt
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t         state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] pick_id;
    logic           pick_found;
    logic           accept;
    logic           release_now;
    logic [IDW-1:0] next_ptr;

    // Search starting at rr_ptr so the most recently served requester goes last.
    always_comb begin
        logic [IDW-1:0] idx;
        idx        = '0;
        pick_found = 1'b0;
        pick_id    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'((int'(rr_ptr) + k) % NREQ);
            if (!pick_found && req_valid[idx]) begin
                pick_found = 1'b1;
                pick_id    = idx;
            end
        end
    end

    assign grant_valid  = (state == GRANT);
    assign accept       = grant_valid && req_valid[grant_id] && !fifo_wr_full;
    assign req_ready    = (grant_valid && !fifo_wr_full) ? (NREQ'(1) << grant_id) : '0;
    assign fifo_wr_en   = accept;
    assign fifo_wr_data = req_data[int'(grant_id)*BITS +: BITS];
    assign release_now  = accept && (req_last[grant_id] || (beat_cnt == CW'(MAX_BURST - 1)));
    assign next_ptr     = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    beat_cnt <= '0;
                    if (pick_found) begin
                        grant_id <= pick_id;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        state    <= IDLE;
                        rr_ptr   <= next_ptr;
                        beat_cnt <= '0;
                    end else if (accept) begin
                        beat_cnt <= beat_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: packet producers modelled per requester,
// FIFO writes captured and compared against hand-derived word order.
module tb_fifo_wr_arbiter;

    localparam int BITS = 32;
    localparam int NREQ = 4;
    localparam int MAXB = 8;

    logic                  wr_clk;
    logic                  wr_rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_last;
    logic [NREQ*BITS-1:0]  req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  fifo_wr_en;
    logic [BITS-1:0]       fifo_wr_data;
    logic                  fifo_wr_full;
    logic                  grant_valid;
    logic [1:0]            grant_id;
    logic [3:0]            beat_cnt;

    int checks;
    int failures;
    int remaining [NREQ];
    int sent      [NREQ];
    int pkt_len   [NREQ];
    logic            full_cmd;
    logic            prev_gv;
    logic [BITS-1:0] captured [$];
    logic [1:0]      glog [$];

    fifo_wr_arbiter #(.BITS(BITS), .NREQ(NREQ), .MAX_BURST(MAXB)) dut (
        .wr_clk(wr_clk),
        .wr_rst_n(wr_rst_n),
        .req_valid(req_valid),
        .req_last(req_last),
        .req_data(req_data),
        .req_ready(req_ready),
        .fifo_wr_en(fifo_wr_en),
        .fifo_wr_data(fifo_wr_data),
        .fifo_wr_full(fifo_wr_full),
        .grant_valid(grant_valid),
        .grant_id(grant_id),
        .beat_cnt(beat_cnt)
    );

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    function automatic logic [BITS-1:0] word(int i, int n);
        return {8'(8'hA0 + i), 24'(n)};
    endfunction

    // One cycle: drive producers at negedge, sample combinational outputs 1 time unit later.
    task automatic step();
        @(negedge wr_clk);
        fifo_wr_full = full_cmd;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = (remaining[i] > 0);
            req_last[i]  = (remaining[i] == 1) || (((sent[i] + 1) % pkt_len[i]) == 0);
            req_data[i*BITS +: BITS] = word(i, sent[i]);
        end
        #1;
        checks++;
        if ($countones(req_ready) > 1) begin
            failures++;
            $display("[TB] FAIL ready_onehot actual=%b required=at most one bit", req_ready);
        end
        checks++;
        if (fifo_wr_en !== |(req_valid & req_ready)) begin
            failures++;
            $display("[TB] FAIL wr_en_vs_accept actual=%b required=%b", fifo_wr_en, |(req_valid & req_ready));
        end
        if (fifo_wr_en) begin
            captured.push_back(fifo_wr_data);
            checks++;
            if (fifo_wr_full) begin
                failures++;
                $display("[TB] FAIL wr_while_full actual=1 required=0");
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                remaining[i]--;
                sent[i]++;
            end
        end
        if (grant_valid && !prev_gv) glog.push_back(grant_id);
        prev_gv = grant_valid;
    endtask

    task automatic clear_producers();
        for (int i = 0; i < NREQ; i++) begin
            remaining[i] = 0;
            sent[i]      = 0;
            pkt_len[i]   = 1;
        end
    endtask

    task automatic apply_reset();
        clear_producers();
        full_cmd = 1'b0;
        wr_rst_n = 1'b0;
        step();
        step();
        wr_rst_n = 1'b1;
        captured.delete();
        glog.delete();
    endtask

    task automatic drain(input string name);
        int guard;
        guard = 0;
        while ((remaining[0] + remaining[1] + remaining[2] + remaining[3]) > 0 && guard < 200) begin
            step();
            guard++;
        end
        checks++;
        if ((remaining[0] + remaining[1] + remaining[2] + remaining[3]) != 0) begin
            failures++;
            $display("[TB] FAIL %s_drain actual=%0d words left required=0", name,
                     remaining[0] + remaining[1] + remaining[2] + remaining[3]);
        end
    endtask

    task automatic test_reset();
        clear_producers();
        for (int i = 0; i < NREQ; i++) begin
            remaining[i] = 5;
            pkt_len[i]   = 5;
        end
        wr_rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (fifo_wr_en !== 1'b0 || req_ready !== '0 || grant_valid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_outputs actual=en%b rdy%b gv%b required=en0 rdy0000 gv0",
                         fifo_wr_en, req_ready, grant_valid);
            end
            checks++;
            if (grant_id !== 2'd0 || beat_cnt !== 4'd0) begin
                failures++;
                $display("[TB] FAIL reset_regs actual=id%0d cnt%0d required=id0 cnt0", grant_id, beat_cnt);
            end
        end
        apply_reset();
    endtask

    task automatic test_single_packet();
        apply_reset();
        remaining[1] = 3;
        pkt_len[1]   = 3;
        step();
        checks++;
        if (grant_valid !== 1'b0 || fifo_wr_en !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_arb_cycle actual=gv%b en%b required=gv0 en0", grant_valid, fifo_wr_en);
        end
        for (int n = 0; n < 3; n++) begin
            step();
            checks++;
            if (grant_valid !== 1'b1 || grant_id !== 2'd1 || fifo_wr_en !== 1'b1) begin
                failures++;
                $display("[TB] FAIL single_beat%0d actual=gv%b id%0d en%b required=gv1 id1 en1",
                         n, grant_valid, grant_id, fifo_wr_en);
            end
            checks++;
            if (fifo_wr_data !== word(1, n) || beat_cnt !== 4'(n)) begin
                failures++;
                $display("[TB] FAIL single_data%0d actual=%h cnt%0d required=%h cnt%0d",
                         n, fifo_wr_data, beat_cnt, word(1, n), n);
            end
        end
        step();
        checks++;
        if (grant_valid !== 1'b0 || fifo_wr_en !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_release actual=gv%b en%b required=gv0 en0", grant_valid, fifo_wr_en);
        end
        // rr_ptr should now be 2: with 0 and 2 pending, 2 wins first.
        glog.delete();
        remaining[0] = 1;
        remaining[2] = 1;
        for (int c = 0; c < 6; c++) step();
        checks++;
        if (glog.size() != 2) begin
            failures++;
            $display("[TB] FAIL rr_after_single_count actual=%0d required=2", glog.size());
        end else if (glog[0] !== 2'd2 || glog[1] !== 2'd0) begin
            failures++;
            $display("[TB] FAIL rr_after_single actual=%0d,%0d required=2,0", glog[0], glog[1]);
        end
    endtask

    task automatic test_fairness();
        logic [1:0] exp_g [5];
        exp_g = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        apply_reset();
        for (int i = 0; i < NREQ; i++) remaining[i] = 3;
        for (int c = 0; c < 10; c++) step();
        checks++;
        if (glog.size() != 5 || captured.size() != 5) begin
            failures++;
            $display("[TB] FAIL fair_counts actual=grants%0d writes%0d required=grants5 writes5",
                     glog.size(), captured.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (glog[k] !== exp_g[k] || captured[k] !== word(exp_g[k], k / 4)) begin
                    failures++;
                    $display("[TB] FAIL fair_grant%0d actual=id%0d %h required=id%0d %h",
                             k, glog[k], captured[k], exp_g[k], word(exp_g[k], k / 4));
                end
            end
        end
        drain("fair");
    endtask

    task automatic test_max_burst();
        logic [BITS-1:0] exp_w [$];
        apply_reset();
        remaining[0] = 16;
        pkt_len[0]   = 16;
        remaining[2] = 4;
        pkt_len[2]   = 4;
        drain("burst");
        for (int n = 0; n < 8; n++)  exp_w.push_back(word(0, n));
        for (int n = 0; n < 4; n++)  exp_w.push_back(word(2, n));
        for (int n = 8; n < 16; n++) exp_w.push_back(word(0, n));
        checks++;
        if (captured.size() != 20) begin
            failures++;
            $display("[TB] FAIL burst_len actual=%0d required=20", captured.size());
        end else begin
            for (int k = 0; k < 20; k++) begin
                checks++;
                if (captured[k] !== exp_w[k]) begin
                    failures++;
                    $display("[TB] FAIL burst_word%0d actual=%h required=%h", k, captured[k], exp_w[k]);
                end
            end
        end
        checks++;
        if (glog.size() != 3 || glog[0] !== 2'd0 || glog[1] !== 2'd2 || glog[2] !== 2'd0) begin
            failures++;
            $display("[TB] FAIL burst_grants actual=%0d grants required=0,2,0", glog.size());
        end
    endtask

    task automatic test_full_stall();
        apply_reset();
        remaining[1] = 4;
        pkt_len[1]   = 4;
        step();
        step();
        step();
        full_cmd = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if (fifo_wr_en !== 1'b0 || req_ready !== '0 || beat_cnt !== 4'd2 ||
                grant_id !== 2'd1 || grant_valid !== 1'b1) begin
                failures++;
                $display("[TB] FAIL full_hold%0d actual=en%b rdy%b cnt%0d id%0d gv%b required=en0 rdy0000 cnt2 id1 gv1",
                         c, fifo_wr_en, req_ready, beat_cnt, grant_id, grant_valid);
            end
        end
        full_cmd = 1'b0;
        step();
        checks++;
        if (fifo_wr_en !== 1'b1 || fifo_wr_data !== word(1, 2) || req_ready !== 4'b0010) begin
            failures++;
            $display("[TB] FAIL full_resume actual=en%b %h rdy%b required=en1 %h rdy0010",
                     fifo_wr_en, fifo_wr_data, req_ready, word(1, 2));
        end
        drain("full");
        checks++;
        if (captured.size() != 4) begin
            failures++;
            $display("[TB] FAIL full_total actual=%0d required=4", captured.size());
        end
    endtask

    task automatic test_reset_mid_packet();
        apply_reset();
        remaining[1] = 1;
        for (int c = 0; c < 3; c++) step();
        remaining[2] = 8;
        pkt_len[2]   = 8;
        for (int c = 0; c < 5; c++) step();
        @(negedge wr_clk);
        wr_rst_n = 1'b0;
        #1;
        checks++;
        if (grant_valid !== 1'b0 || req_ready !== '0 || fifo_wr_en !== 1'b0 ||
            beat_cnt !== 4'd0 || grant_id !== 2'd0) begin
            failures++;
            $display("[TB] FAIL midreset_async actual=gv%b rdy%b en%b cnt%0d id%0d required=all zero",
                     grant_valid, req_ready, fifo_wr_en, beat_cnt, grant_id);
        end
        checks++;
        if (captured.size() != 5) begin
            failures++;
            $display("[TB] FAIL midreset_written actual=%0d required=5", captured.size());
        end
        remaining[2] = 0;
        step();
        step();
        wr_rst_n = 1'b1;
        glog.delete();
        remaining[1] = 1;
        remaining[3] = 1;
        for (int c = 0; c < 6; c++) step();
        checks++;
        if (glog.size() < 1 || glog[0] !== 2'd1) begin
            failures++;
            $display("[TB] FAIL midreset_rr actual=%0d grants first=%0d required=first 1",
                     glog.size(), (glog.size() > 0) ? glog[0] : 2'd0);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        checks       = 0;
        failures     = 0;
        prev_gv      = 1'b0;
        full_cmd     = 1'b0;
        fifo_wr_full = 1'b0;
        req_valid    = '0;
        req_last     = '0;
        req_data     = '0;
        wr_rst_n     = 1'b0;
        test_reset();
        test_single_packet();
        test_fairness();
        test_max_burst();
        test_full_stall();
        test_reset_mid_packet();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
